// File: rtl/gray_step_arbiter.sv
// gray_step_arbiter: round-robin sharing of one 3-bit Gray counter between two requesters
// Each job drives En for exactly Steps cycles, then captures GrayIn/OvfIn and pulses Done.
// Ports: Clk/Reset (sync, active-high); Req0/Steps0, Req1/Steps1 requests;
//   Grant0/Grant1 (RUN..DONE), Done0/Done1 (one-cycle completion pulse);
//   En, GrayIn, OvfIn to/from the shared counter; Result/ResultOvf captured at job end;
//   Busy (RUN or DONE); Err sticky Gray-step error.
// Macro GRAY_STEP_CHECK_EN enables the Gray single-bit-step checker; otherwise Err is tied 0.
module gray_step_arbiter #(
    parameter int STEP_W = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req0,
    input  logic [STEP_W-1:0] Steps0,
    input  logic              Req1,
    input  logic [STEP_W-1:0] Steps1,
    output logic              Grant0,
    output logic              Grant1,
    output logic              Done0,
    output logic              Done1,
    output logic              En,
    input  logic [2:0]        GrayIn,
    input  logic              OvfIn,
    output logic [2:0]        Result,
    output logic              ResultOvf,
    output logic              Busy,
    output logic              Err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    logic [1:0]        r_state;
    logic              r_lp;
    logic [STEP_W-1:0] r_cnt;
    logic              r_grant0, r_grant1, r_done0, r_done1;
    logic [2:0]        r_result;
    logic              r_ovf;
    logic              w_elig0, w_elig1, w_pick1;
    logic [STEP_W-1:0] w_steps;
    // a requester still in its Done cycle is not eligible, so a held Req is not re-served
    assign w_elig0 = Req0 & ~r_done0;
    assign w_elig1 = Req1 & ~r_done1;
    assign w_pick1 = w_elig1 & (~w_elig0 | ~r_lp);
    assign w_steps = w_pick1 ? Steps1 : Steps0;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_lp     <= 1'b1;
            r_cnt    <= '0;
            r_grant0 <= 1'b0;
            r_grant1 <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_result <= 3'b000;
            r_ovf    <= 1'b0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                S_IDLE: if (w_elig0 | w_elig1) begin
                    r_lp     <= w_pick1;
                    r_cnt    <= w_steps;
                    r_grant0 <= ~w_pick1;
                    r_grant1 <= w_pick1;
                    r_state  <= (w_steps != '0) ? S_RUN : S_DONE;
                end
                S_RUN: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == STEP_W'(1)) r_state <= S_DONE;
                end
                S_DONE: begin
                    r_result <= GrayIn;
                    r_ovf    <= OvfIn;
                    r_done0  <= r_grant0;
                    r_done1  <= r_grant1;
                    r_grant0 <= 1'b0;
                    r_grant1 <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign En        = (r_state == S_RUN);
    assign Busy      = (r_state != S_IDLE);
    assign Grant0    = r_grant0;
    assign Grant1    = r_grant1;
    assign Done0     = r_done0;
    assign Done1     = r_done1;
    assign Result    = r_result;
    assign ResultOvf = r_ovf;
`ifdef GRAY_STEP_CHECK_EN
    logic [2:0] r_prev;
    logic       r_en_d, r_err;
    logic       w_one;
    // after every stepped cycle the code must differ from the previous one in exactly one bit
    assign w_one = $onehot(GrayIn ^ r_prev);
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_prev <= 3'b000;
            r_en_d <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_prev <= GrayIn;
            r_en_d <= En;
            if (r_en_d && !w_one) r_err <= 1'b1;
        end
    end
    assign Err = r_err;
`else
    assign Err = 1'b0;
`endif
endmodule

// File: tb/tb_gray_step_arbiter.sv
// tb_gray_step_arbiter: random and directed checks of gray_step_arbiter against a job-level model
module tb_gray_step_arbiter;
    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Req0 = 1'b0, Req1 = 1'b0;
    logic [3:0] Steps0 = 4'd0, Steps1 = 4'd0;
    logic       Grant0, Grant1, Done0, Done1, En, ResultOvf, Busy, Err, OvfIn;
    logic [2:0] GrayIn, Result;
    logic [2:0] c_idx;
    logic       c_ovf;
    logic       force_en = 1'b0;
    logic [2:0] force_val = 3'b000;
    int checks = 0, errors = 0;
    int m_total;
    logic m_lp;
    logic [2:0] gtab [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    always #5 Clk = ~Clk;
    always @(posedge Clk) begin
        if (Reset) begin
            c_idx <= 3'd0;
            c_ovf <= 1'b0;
        end else if (En) begin
            if (c_idx == 3'd7) c_ovf <= 1'b1;
            c_idx <= c_idx + 3'd1;
        end
    end
    assign GrayIn = force_en ? force_val : (c_idx ^ (c_idx >> 1));
    assign OvfIn  = c_ovf;
    gray_step_arbiter #(.STEP_W(4)) dut (
        .Clk(Clk), .Reset(Reset), .Req0(Req0), .Steps0(Steps0), .Req1(Req1), .Steps1(Steps1),
        .Grant0(Grant0), .Grant1(Grant1), .Done0(Done0), .Done1(Done1), .En(En),
        .GrayIn(GrayIn), .OvfIn(OvfIn), .Result(Result), .ResultOvf(ResultOvf),
        .Busy(Busy), .Err(Err)
    );
    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        Req0 = 1'b0;
        Req1 = 1'b0;
        force_en = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        m_total = 0;
        m_lp = 1'b1;
    endtask
    task automatic run_jobs(input logic r0, input logic r1, input int s0, input int s1);
        int first, c, en_cnt;
        int n [2];
        int exp_done [2];
        int got_done [2];
        logic [2:0] exp_res [2];
        logic exp_ovf [2];
        logic req [2];
        logic stray;
        req[0] = r0; req[1] = r1; n[0] = s0; n[1] = s1;
        exp_done = '{-1, -1}; got_done = '{-1, -1};
        exp_res = '{3'b000, 3'b000}; exp_ovf = '{1'b0, 1'b0};
        first = (r0 && r1) ? (m_lp ? 0 : 1) : (r0 ? 0 : 1);
        c = 0;
        for (int k = 0; k < 2; k++) begin
            int x;
            x = (k == 0) ? first : 1 - first;
            if (req[x]) begin
                m_total += n[x];
                exp_res[x] = gtab[m_total % 8];
                exp_ovf[x] = (m_total >= 8);
                exp_done[x] = c + n[x] + 2;
                c = exp_done[x];
                m_lp = x[0];
            end
        end
        @(negedge Clk);
        Req0 = r0; Req1 = r1; Steps0 = 4'(s0); Steps1 = 4'(s1);
        en_cnt = 0; stray = 1'b0; c = 0;
        while (c < 80 && ((req[0] && got_done[0] < 0) || (req[1] && got_done[1] < 0))) begin
            @(negedge Clk);
            c++;
            en_cnt += int'(En);
            if ((Grant0 && Grant1) || (Grant0 && !r0) || (Grant1 && !r1) || (Done0 && !r0) || (Done1 && !r1) || Err) stray = 1'b1;
            if (c == 1) begin
                if (first == 0) Steps0 = 4'($urandom); else Steps1 = 4'($urandom);
            end
            if (Done0) begin
                got_done[0] = c;
                Req0 = 1'b0;
                checks++;
                if ({Result, ResultOvf} !== {exp_res[0], exp_ovf[0]}) begin
                    errors++;
                    $display("FAIL result0 steps=%0d,%0d got %b/%b exp %b/%b", s0, s1, Result, ResultOvf, exp_res[0], exp_ovf[0]);
                end
            end
            if (Done1) begin
                got_done[1] = c;
                Req1 = 1'b0;
                checks++;
                if ({Result, ResultOvf} !== {exp_res[1], exp_ovf[1]}) begin
                    errors++;
                    $display("FAIL result1 steps=%0d,%0d got %b/%b exp %b/%b", s0, s1, Result, ResultOvf, exp_res[1], exp_ovf[1]);
                end
            end
        end
        checks++;
        if (got_done[0] != exp_done[0] || got_done[1] != exp_done[1]) begin
            errors++;
            $display("FAIL done_cycle got %0d,%0d exp %0d,%0d", got_done[0], got_done[1], exp_done[0], exp_done[1]);
        end
        checks++;
        if (en_cnt != (r0 ? s0 : 0) + (r1 ? s1 : 0)) begin
            errors++;
            $display("FAIL en_cycles got %0d exp %0d", en_cnt, (r0 ? s0 : 0) + (r1 ? s1 : 0));
        end
        checks++;
        if (stray !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL grant_integrity got stray=%b busy=%b exp 0/0", stray, Busy);
        end
    endtask
    task automatic test_reset();
        do_reset();
        checks++;
        if ({Grant0, Grant1, Done0, Done1, En, Result, ResultOvf, Busy, Err} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0", {Grant0, Grant1, Done0, Done1, En, Result, ResultOvf, Busy, Err});
        end
    endtask
    task automatic test_single();
        do_reset();
        run_jobs(1'b1, 1'b0, 3, 0);
    endtask
    task automatic test_both();
        do_reset();
        run_jobs(1'b1, 1'b1, 2, 1);
    endtask
    task automatic test_zero();
        run_jobs(1'b0, 1'b1, 0, 0);
    endtask
    task automatic test_wrap();
        do_reset();
        run_jobs(1'b1, 1'b0, 9, 0);
    endtask
    task automatic test_reset_mid();
        do_reset();
        @(negedge Clk);
        Req0 = 1'b1; Steps0 = 4'd5;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        Req0 = 1'b0;
        @(negedge Clk);
        checks++;
        if ({Grant0, Grant1, Done0, Done1, En, Result, ResultOvf, Busy, Err} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs got %b exp 0", {Grant0, Grant1, Done0, Done1, En, Result, ResultOvf, Busy, Err});
        end
        Reset = 1'b0;
        m_total = 0;
        m_lp = 1'b1;
        @(negedge Clk);
        checks++;
        if ({Done0, Busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_nodone got %b exp 00", {Done0, Busy});
        end
        run_jobs(1'b1, 1'b0, 2, 0);
    endtask
    task automatic test_random();
        do_reset();
        for (int i = 0; i < 30; i++) begin
            logic r0, r1;
            r0 = 1'($urandom);
            r1 = r0 ? 1'($urandom) : 1'b1;
            run_jobs(r0, r1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end
    endtask
`ifdef GRAY_STEP_CHECK_EN
    task automatic test_err();
        do_reset();
        @(negedge Clk);
        Req0 = 1'b1; Steps0 = 4'd3;
        repeat (2) @(negedge Clk);
        force_en = 1'b1;
        force_val = 3'b011;
        @(negedge Clk);
        force_en = 1'b0;
        Req0 = 1'b0;
        checks++;
        if (Err !== 1'b1) begin
            errors++;
            $display("FAIL err_set got %b exp 1", Err);
        end
        repeat (5) @(negedge Clk);
        checks++;
        if (Err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got %b exp 1", Err);
        end
        do_reset();
        checks++;
        if (Err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got %b exp 0", Err);
        end
    endtask
`endif
    initial begin
        test_reset();
        test_single();
        test_both();
        test_zero();
        test_wrap();
        test_reset_mid();
        test_random();
`ifdef GRAY_STEP_CHECK_EN
        test_err();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
